mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares one memory port between NUM_REQ requesters (e.g. core fetch, core load/store, DMA).
- Sits between the requesters and the memory controller.
- Serialises requests into single-cycle command pulses and waits for the memory's acknowledge.
- Returns the read data, plus a one-cycle ack, to the requester that owns the grant.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, address width in bits.
- DATA_WIDTH, 32, data width in bits.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester request level.
- wr  in  NUM_REQ  per-requester write flag (1 = write, 0 = read).
- addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- wr_data  in  NUM_REQ*DATA_WIDTH  flattened write data, packed the same way.
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rd_data  out  DATA_WIDTH  registered read data; valid in the cycle ack is high.
- busy  out  1  high in every state except IDLE.
- mem_rd_req  out  1  one-cycle read command.
- mem_wr_req  out  1  one-cycle write command.
- mem_addr  out  ADDR_WIDTH  command address.
- mem_wr_data  out  DATA_WIDTH  command write data.
- mem_rd_data  in  DATA_WIDTH  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; last_grant = NUM_REQ-1, so requester 0 has top priority.
  - All outputs go to 0: ack, rd_data, busy, mem_rd_req, mem_wr_req, mem_addr, mem_wr_data.
  - Any in-flight transaction is abandoned; no ack is issued for it.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If req is non-zero, grant g = the first asserted index searching (last_grant+1) mod NUM_REQ upward with wrap.
  - Latch g, wr[g], addr[g] and wr_data[g]; go to ISSUE.
  - If req is zero, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_rd_req = ~wr_g and mem_wr_req = wr_g.
  - mem_addr and mem_wr_data are driven from the latched values and held until the next grant.
  - mem_ack in this cycle is ignored.
  - Go to WAIT.
- WAIT:
  - Command pulses are 0.
  - On mem_ack: rd_data <= mem_rd_data (for writes too), last_grant <= g, go to ACK.
  - Wait indefinitely; there is no timeout.
- ACK (exactly 1 cycle):
  - ack[g] = 1 and rd_data is valid.
  - Go to IDLE.
- rd_data holds its value until the next completion.
- Requester rules:
  - Hold req, wr, addr and wr_data stable from assertion until ack is seen.
  - Deassert req by the edge after ack, otherwise the same request is re-issued.
- Latency: with req high before edge E0 and mem_ack in the first WAIT cycle, mem_*_req is high in cycle E0..E1 and ack is high in cycle E2..E3. Minimum 4 cycles per transaction; the IDLE cycle is included.
- Fairness: a requester that just completed has the lowest priority at the next arbitration. Any asserted req is granted within NUM_REQ transactions.
- Requests arriving while busy=1 are not lost: they are evaluated on return to IDLE.
- Simultaneous request and ack: a req whose ack is high in the same cycle is treated as a new request only if still high at the IDLE sampling edge.

Test Plan:
- Reset hold, then release: rst=0 for 2 cycles, then rst=1 with req=0 -> every output is 0 and busy=0 while idle.
- Single read: req=4'b0010, wr=0, addr[1]=32'h100, memory acks 1 cycle after mem_rd_req with data 32'hDEADBEEF -> mem_rd_req pulses one cycle with mem_addr=32'h100; ack=4'b0010 exactly 1 cycle later with rd_data=32'hDEADBEEF.
- Single write: req=4'b0001, wr=1, addr[0]=32'h40, wr_data[0]=32'h12345678 -> mem_wr_req pulses once with mem_addr=32'h40 and mem_wr_data=32'h12345678; mem_rd_req stays 0; ack=4'b0001 follows.
- Round robin: req=4'b1111 held, each requester dropping its req after its ack -> grant order 0,1,2,3; then re-assert req[0] and req[2] -> order 0,2 after requester 3.
- Slow memory: mem_ack delayed 10 cycles -> busy=1 throughout, no second command issued, a single ack pulse at the end.
- Reset mid-operation: rst=0 while in WAIT -> all outputs 0 immediately (asynchronous); a late mem_ack after release produces no ack; the next grant goes to requester 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between NUM_REQ requesters
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   req          per-requester request level
//   wr           per-requester write flag (1 = write, 0 = read)
//   addr         flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   wr_data      flattened write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack          one-hot, one-cycle completion pulse to the granted requester
//   rd_data      registered read data, valid while ack is high, held until next completion
//   busy         high in every state except IDLE
//   mem_rd_req   one-cycle read command
//   mem_wr_req   one-cycle write command
//   mem_addr     command address, held until the next grant
//   mem_wr_data  command write data, held until the next grant
//   mem_rd_data  memory read data, valid with mem_ack
//   mem_ack      memory completion pulse
module mem_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  wr_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           busy,
    output logic                           mem_rd_req,
    output logic                           mem_wr_req,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wr_data,
    input  logic [DATA_WIDTH-1:0]          mem_rd_data,
    input  logic                           mem_ack
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [GW-1:0]           last_grant, last_grant_nxt;
    logic [GW-1:0]           grant, grant_nxt;
    logic [NUM_REQ-1:0]      ack_nxt;
    logic [DATA_WIDTH-1:0]   rd_data_nxt;
    logic                    busy_nxt;
    logic                    mem_rd_req_nxt;
    logic                    mem_wr_req_nxt;
    logic [ADDR_WIDTH-1:0]   mem_addr_nxt;
    logic [DATA_WIDTH-1:0]   mem_wr_data_nxt;

    // Round-robin pick: first asserted req starting one past last_grant,
    // wrapping modulo NUM_REQ (which need not be a power of two).
    logic [GW-1:0]           pick;
    logic                    pick_valid;
    logic [GW-1:0]           cand;

    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NUM_REQ);
            if (!pick_valid && req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Select the picked requester's command fields.
    logic                    pick_wr;
    logic [ADDR_WIDTH-1:0]   pick_addr;
    logic [DATA_WIDTH-1:0]   pick_wdata;

    always_comb begin
        pick_wr    = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == GW'(i)) begin
                pick_wr    = wr[i];
                pick_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                pick_wdata = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and next-output logic; every output is registered so the
    // command pulse appears in the ISSUE cycle and ack in the ACK cycle.
    always_comb begin
        state_nxt       = state;
        last_grant_nxt  = last_grant;
        grant_nxt       = grant;
        ack_nxt         = '0;
        rd_data_nxt     = rd_data;
        mem_rd_req_nxt  = 1'b0;
        mem_wr_req_nxt  = 1'b0;
        mem_addr_nxt    = mem_addr;
        mem_wr_data_nxt = mem_wr_data;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_nxt       = pick;
                    mem_rd_req_nxt  = ~pick_wr;
                    mem_wr_req_nxt  = pick_wr;
                    mem_addr_nxt    = pick_addr;
                    mem_wr_data_nxt = pick_wdata;
                    state_nxt       = ISSUE;
                end
            end
            ISSUE: begin
                // mem_ack arriving in the command cycle is deliberately ignored.
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_ack) begin
                    rd_data_nxt    = mem_rd_data;
                    last_grant_nxt = grant;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        ack_nxt[i] = (grant == GW'(i));
                    end
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_grant  <= GW'(NUM_REQ - 1);
            grant       <= '0;
            ack         <= '0;
            rd_data     <= '0;
            busy        <= 1'b0;
            mem_rd_req  <= 1'b0;
            mem_wr_req  <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            grant       <= grant_nxt;
            ack         <= ack_nxt;
            rd_data     <= rd_data_nxt;
            busy        <= busy_nxt;
            mem_rd_req  <= mem_rd_req_nxt;
            mem_wr_req  <= mem_wr_req_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_wr_data <= mem_wr_data_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      wr = '0;
    logic [N*AW-1:0]   addr = '0;
    logic [N*DW-1:0]   wr_data = '0;
    logic [N-1:0]      ack;
    logic [DW-1:0]     rd_data;
    logic              busy;
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wr_data;
    logic [DW-1:0]     mem_rd_data = '0;
    logic              mem_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: who completed last, and each requester's command.
    int              last_g = N - 1;
    logic [AW-1:0]   a_tab[N];
    logic            w_tab[N];
    logic [DW-1:0]   d_tab[N];

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .wr          (wr),
        .addr        (addr),
        .wr_data     (wr_data),
        .ack         (ack),
        .rd_data     (rd_data),
        .busy        (busy),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .mem_ack     (mem_ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        a_tab[i] = a;
        w_tab[i] = w;
        d_tab[i] = d;
        addr[i*AW +: AW]    = a;
        wr[i]               = w;
        wr_data[i*DW +: DW] = d;
        req[i]              = 1'b1;
    endtask

    task automatic arrive();
        int i;
        if ($urandom_range(0, 3) == 0) begin
            i = $urandom_range(0, N - 1);
            if (!req[i]) set_req(i, $urandom, 1'($urandom_range(0, 1)), $urandom);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 64'(ack), 64'd0);
        check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_mem_rd_req"}, 64'(mem_rd_req), 64'd0);
        check({tag, "_mem_wr_req"}, 64'(mem_wr_req), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wr_data"}, 64'(mem_wr_data), 64'd0);
    endtask

    // One full transaction as seen from the memory side. Called at a negedge
    // while the DUT is idle (or in its last ACK/IDLE cycle); returns at the
    // negedge of the IDLE cycle that follows the ack pulse.
    task automatic run_txn(input int delay, input bit spur, input logic [DW-1:0] rdat,
                           input bit rnd_arrive, output int g);
        int n;
        n = 0;
        g = -1;
        while (!(mem_rd_req || mem_wr_req) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(mem_rd_req || mem_wr_req)) begin
            check("cmd_timeout", 64'd0, 64'd1);
            return;
        end
        g = rr_pick(last_g, req);
        if (g < 0) begin
            check("cmd_without_req", 64'd1, 64'd0);
            return;
        end
        check("cmd_addr", 64'(mem_addr), 64'(a_tab[g]));
        check("cmd_wdata", 64'(mem_wr_data), 64'(d_tab[g]));
        check("cmd_wr", 64'(mem_wr_req), 64'(w_tab[g]));
        check("cmd_rd", 64'(mem_rd_req), 64'(!w_tab[g]));
        check("busy_issue", 64'(busy), 64'd1);
        mem_ack     = spur;
        mem_rd_data = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        check("cmd_single_pulse", 64'(mem_rd_req | mem_wr_req), 64'd0);
        check("no_early_ack", 64'(ack), 64'd0);
        for (int k = 0; k < delay; k++) begin
            if (rnd_arrive) arrive();
            @(negedge clk);
            check("busy_wait", 64'(busy), 64'd1);
            check("no_cmd_wait", 64'(mem_rd_req | mem_wr_req), 64'd0);
            check("no_ack_wait", 64'(ack), 64'd0);
        end
        mem_ack     = 1'b1;
        mem_rd_data = rdat;
        @(negedge clk);
        mem_ack     = 1'b0;
        mem_rd_data = $urandom;
        check("ack_onehot", 64'(ack), 64'(1 << g));
        check("ack_rd_data", 64'(rd_data), 64'(rdat));
        check("busy_ack", 64'(busy), 64'd1);
        last_g = g;
        req[g] = 1'b0;
        @(negedge clk);
        check("ack_single_pulse", 64'(ack), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        check("rd_data_hold", 64'(rd_data), 64'(rdat));
    endtask

    initial begin
        int g;
        int n;
        int order_rr[4];
        int order_02[2];
        order_rr = '{0, 1, 2, 3};
        order_02 = '{0, 2};

        // Reset held for two cycles, then released with nothing requested.
        @(negedge clk);
        @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("after_reset");

        // Round robin with all four requesting from reset priority.
        for (int i = 0; i < N; i++) set_req(i, $urandom, 1'($urandom_range(0, 1)), $urandom);
        for (int t = 0; t < 4; t++) begin
            run_txn(0, 0, $urandom, 0, g);
            check("rr_order", 64'(g), 64'(order_rr[t]));
        end
        set_req(0, $urandom, 1'b0, $urandom);
        set_req(2, $urandom, 1'b1, $urandom);
        for (int t = 0; t < 2; t++) begin
            run_txn(0, 0, $urandom, 0, g);
            check("rr_order_02", 64'(g), 64'(order_02[t]));
        end

        // Single read on requester 1.
        set_req(1, 32'h100, 1'b0, 32'h0);
        run_txn(0, 0, 32'hDEADBEEF, 0, g);
        check("single_read_grant", 64'(g), 64'd1);

        // Single write on requester 0.
        set_req(0, 32'h40, 1'b1, 32'h12345678);
        run_txn(0, 0, $urandom, 0, g);
        check("single_write_grant", 64'(g), 64'd0);

        // Slow memory with a spurious ack in the command cycle.
        set_req(3, $urandom, 1'b0, $urandom);
        run_txn(10, 1, $urandom, 0, g);
        check("slow_grant", 64'(g), 64'd3);

        // Reset in the middle of WAIT: everything clears immediately.
        set_req(2, $urandom, 1'b0, $urandom);
        n = 0;
        while (!(mem_rd_req || mem_wr_req) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midrst_cmd_seen", 64'(mem_rd_req | mem_wr_req), 64'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("midrst_async");
        req    = '0;
        last_g = N - 1;
        @(negedge clk);
        rst = 1'b1;
        mem_ack     = 1'b1;
        mem_rd_data = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_no_late_ack", 64'(ack), 64'd0);
            check("midrst_idle", 64'(busy), 64'd0);
        end
        for (int i = 0; i < N; i++) set_req(i, $urandom, 1'($urandom_range(0, 1)), $urandom);
        run_txn(0, 0, $urandom, 0, g);
        check("midrst_first_grant", 64'(g), 64'd0);

        // Randomized traffic against the round-robin model.
        for (int t = 0; t < 60; t++) begin
            if (req == '0) set_req($urandom_range(0, N - 1), $urandom, 1'($urandom_range(0, 1)), $urandom);
            arrive();
            run_txn($urandom_range(0, 6), 1'($urandom_range(0, 2) == 0), $urandom, 1, g);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
